// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one full-adder cell plus a registered carry, LSB first.
// Optional SERIAL_SUB_EN adds a SUB port that turns the operation into A - B.
module serial_adder #(
    parameter int unsigned N = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         START,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Ci,
`ifdef SERIAL_SUB_EN
    input  logic         SUB,
`endif
    output logic         BUSY,
    output logic         DONE,
    output logic [N-1:0] S,
    output logic         Co
);

    localparam int unsigned CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e         r_state;
    logic [N-1:0]   r_a_sr;
    logic [N-1:0]   r_b_sr;
    logic [N-1:0]   r_s_sr;
    logic           r_c;
    logic           r_co;
    logic           r_busy;
    logic           r_done;
    logic [CW-1:0]  r_cnt;

    logic           w_bit;
    logic           w_carry;
    logic [N-1:0]   w_b_load;
    logic           w_c_load;
    logic [N-1:0]   w_s_next;

`ifdef SERIAL_SUB_EN
    // Subtraction as A + ~B + 1; the forced carry-in replaces Ci.
    assign w_b_load = SUB ? ~B : B;
    assign w_c_load = SUB ? 1'b1 : Ci;
`else
    assign w_b_load = B;
    assign w_c_load = Ci;
`endif

    assign w_bit   = r_a_sr[0] ^ r_b_sr[0] ^ r_c;
    assign w_carry = (r_a_sr[0] & r_b_sr[0]) | (r_a_sr[0] & r_c) | (r_b_sr[0] & r_c);

    always_comb begin
        w_s_next        = r_s_sr >> 1;
        w_s_next[N-1]   = w_bit;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= StIdle;
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_s_sr  <= '0;
            r_c     <= 1'b0;
            r_co    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                StIdle, StDone: begin
                    r_done <= 1'b0;
                    if (START) begin
                        r_a_sr  <= A;
                        r_b_sr  <= w_b_load;
                        r_c     <= w_c_load;
                        r_s_sr  <= '0;
                        r_co    <= 1'b0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= StShift;
                    end else begin
                        r_state <= StIdle;
                    end
                end
                StShift: begin
                    r_s_sr <= w_s_next;
                    r_c    <= w_carry;
                    r_a_sr <= r_a_sr >> 1;
                    r_b_sr <= r_b_sr >> 1;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == CW'(N - 1)) begin
                        r_co    <= w_carry;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= StDone;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign BUSY = r_busy;
    assign DONE = r_done;
    assign S    = r_s_sr;
    assign Co   = r_co;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: N=8 instance for directed vectors, N=1 instance
// for the full-adder truth table.
module tb_serial_adder;

    typedef struct packed {
        logic [7:0] s;
        logic       co;
    } res8_t;

    typedef struct packed {
        logic s;
        logic co;
    } res1_t;

    logic       clk;
    logic       rst;
    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       ci8;
    logic       sub8;
    logic       busy8;
    logic       done8;
    logic [7:0] s8;
    logic       co8;

    logic       start1;
    logic       a1;
    logic       b1;
    logic       ci1;
    logic       sub1;
    logic       busy1;
    logic       done1;
    logic       s1;
    logic       co1;

    int checks   = 0;
    int failures = 0;

    res8_t q8[$];
    res1_t q1[$];

    serial_adder #(.N(8)) u_dut8 (
        .CLK   (clk),
        .RST   (rst),
        .START (start8),
        .A     (a8),
        .B     (b8),
        .Ci    (ci8),
`ifdef SERIAL_SUB_EN
        .SUB   (sub8),
`endif
        .BUSY  (busy8),
        .DONE  (done8),
        .S     (s8),
        .Co    (co8)
    );

    serial_adder #(.N(1)) u_dut1 (
        .CLK   (clk),
        .RST   (rst),
        .START (start1),
        .A     (a1),
        .B     (b1),
        .Ci    (ci1),
`ifdef SERIAL_SUB_EN
        .SUB   (sub1),
`endif
        .BUSY  (busy1),
        .DONE  (done1),
        .S     (s1),
        .Co    (co1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitors: every DONE pops one expected result.
    always @(negedge clk) begin
        if (!rst && done8) begin
            if (q8.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dut8_unexpected_done actual=%0h_%0h required=none", s8, co8);
            end else begin
                res8_t e;
                e = q8.pop_front();
                check("dut8_sum", {24'd0, s8}, {24'd0, e.s});
                check("dut8_co", {31'd0, co8}, {31'd0, e.co});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && done1) begin
            if (q1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dut1_unexpected_done actual=%0h_%0h required=none", s1, co1);
            end else begin
                res1_t e;
                e = q1.pop_front();
                check("dut1_sum", {31'd0, s1}, {31'd0, e.s});
                check("dut1_co", {31'd0, co1}, {31'd0, e.co});
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                            input logic sub, input logic [7:0] exp_s, input logic exp_co);
        q8.push_back('{s: exp_s, co: exp_co});
        a8     = a;
        b8     = b;
        ci8    = ci;
        sub8   = sub;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic wait_done(input string name, output int lat, output int busy_cnt);
        bit got;
        got      = 1'b0;
        lat      = 0;
        busy_cnt = busy8 ? 1 : 0;
        for (int i = 1; i <= 30 && !got; i++) begin
            @(negedge clk);
            if (done8) begin
                got = 1'b1;
                lat = i;
            end else if (busy8) begin
                busy_cnt++;
            end
        end
        check({name, "_done_seen"}, {31'd0, got}, 32'd1);
    endtask

    initial begin
        int lat;
        int bcnt;
        logic [4:0] tv [8];

        rst    = 1'b1;
        start8 = 1'b0;
        a8     = '0;
        b8     = '0;
        ci8    = 1'b0;
        sub8   = 1'b0;
        start1 = 1'b0;
        a1     = 1'b0;
        b1     = 1'b0;
        ci1    = 1'b0;
        sub1   = 1'b0;

        repeat (2) @(negedge clk);
        check("reset_state", {20'd0, s8, co8, busy8, done8, s1, co1, busy1, done1},
              32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: basic add, latency and BUSY width
        start_op(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0);
        check("t1_busy_after_start", {31'd0, busy8}, 32'd1);
        wait_done("t1", lat, bcnt);
        check("t1_done_latency", lat, 32'd8);
        check("t1_busy_cycles", bcnt, 32'd8);
        check("t1_busy_low_in_done", {31'd0, busy8}, 32'd0);
        @(negedge clk);

        // 2: carry-out, carry-in, result hold
        start_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
        wait_done("t2a", lat, bcnt);
        @(negedge clk);
        start_op(8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0);
        a8 = 8'hAA;
        b8 = 8'h55;
        ci8 = 1'b0;
        wait_done("t2b", lat, bcnt);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t2_hold", {22'd0, s8, co8, done8}, {22'd0, 8'h01, 1'b0, 1'b0});
        end

        // 3: START during SHIFT ignored
        start_op(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0);
        repeat (2) @(negedge clk);
        a8     = 8'hFF;
        b8     = 8'hFF;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait_done("t3", lat, bcnt);
        repeat (12) @(negedge clk);
        check("t3_busy_idle", {31'd0, busy8}, 32'd0);

        // 4: asynchronous reset mid-operation
        q8.push_back('{s: 8'h00, co: 1'b0});
        void'(q8.pop_back());
        a8     = 8'hF0;
        b8     = 8'h0F;
        ci8    = 1'b0;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        check("t4_busy_before_rst", {31'd0, busy8}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t4_async_rst", {21'd0, s8, co8, busy8, done8}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("t4_no_done_after_rst", {31'd0, done8}, 32'd0);
        start_op(8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0);
        wait_done("t4", lat, bcnt);
        @(negedge clk);

        // 5: back-to-back, START high during the DONE cycle
        start_op(8'h11, 8'h22, 1'b0, 1'b0, 8'h33, 1'b0);
        wait_done("t5a", lat, bcnt);
        start_op(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1);
        check("t5_no_idle_gap", {31'd0, busy8}, 32'd1);
        wait_done("t5b", lat, bcnt);
        check("t5_done_spacing", lat + 1, 32'd9);
        @(negedge clk);

`ifdef SERIAL_SUB_EN
        // 6: subtraction
        start_op(8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1);
        wait_done("t6a", lat, bcnt);
        @(negedge clk);
        start_op(8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0);
        wait_done("t6b", lat, bcnt);
        @(negedge clk);
        sub8 = 1'b0;
`endif

        // N=1 full-adder truth table: {a, b, ci, s, co}
        tv[0] = 5'b000_00;
        tv[1] = 5'b001_10;
        tv[2] = 5'b010_10;
        tv[3] = 5'b011_01;
        tv[4] = 5'b100_10;
        tv[5] = 5'b101_01;
        tv[6] = 5'b110_01;
        tv[7] = 5'b111_11;
        for (int i = 0; i < 8; i++) begin
            bit got;
            int l1;
            got = 1'b0;
            l1  = 0;
            q1.push_back('{s: tv[i][1], co: tv[i][0]});
            a1     = tv[i][4];
            b1     = tv[i][3];
            ci1    = tv[i][2];
            start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
            for (int k = 1; k <= 5 && !got; k++) begin
                @(negedge clk);
                if (done1) begin
                    got = 1'b1;
                    l1  = k;
                end
            end
            check("n1_done_latency", l1, 32'd1);
            @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("q8_drained", q8.size(), 32'd0);
        check("q1_drained", q1.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
